vga_text_vram_arbiter: RTL

- Shares one single-port synchronous VRAM (600 × 32-bit words, 1-cycle read latency) between the Avalon-MM slave and the text-mode display fetch path.
- Owns the control register at word 600 and the VSYNC toggle bit.
- Display fetches have strict priority and always return in fixed time; Avalon accesses are stretched with waitrequest only as long as needed.
- Sits between the Avalon-MM interface top level, the character/pixel fetch logic and the VRAM macro.

---
 rtl/vga_text_pkg.sv | 26 ++
 rtl/vga_text_ctrl_reg.sv | 44 ++++
 rtl/vga_text_vram_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode VGA VRAM arbiter.
// Covers the VRAM/CTRL address map, the control register layout and the Avalon FSM states.
package vga_text_pkg;

  localparam int          VRAM_WORDS = 600;
  localparam int          CTRL_ADDR  = 600;
  localparam logic [31:0] CTRL_RESET = 32'h01FFE000;

  // Colour nibbles sit in bits 24:1; bit 0 is the VSYNC toggle.
  typedef struct packed {
    logic [6:0] rsvd;
    logic [3:0] fgd_r;
    logic [3:0] fgd_g;
    logic [3:0] fgd_b;
    logic [3:0] bkg_r;
    logic [3:0] bkg_g;
    logic [3:0] bkg_b;
    logic       vsync;
  } ctrl_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } avl_state_e;

endpackage

// File: rtl/vga_text_ctrl_reg.sv
// Control register for the text display.
// Byte-enabled writes reach bits 31:1; bit 0 toggles on each falling edge of VS.
module vga_text_ctrl_reg
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        vs,
  output logic [31:0] ctrl
);

  ctrl_t       ctrl_q;
  ctrl_t       ctrl_nxt;
  logic        vs_q;
  logic        vs_fall;
  logic [31:0] wmask;

  assign vs_fall = vs_q & ~vs;
  assign wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & 32'hFFFF_FFFE;

  // NOTE: always_comb assigns every output first, so no path can leave a latch behind.
  always_comb begin
    ctrl_nxt = ctrl_q;
    if (we) ctrl_nxt = ctrl_t'((ctrl_q & ~wmask) | (wdata & wmask));
    ctrl_nxt.vsync = ctrl_q.vsync ^ vs_fall;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= ctrl_t'(CTRL_RESET);
      vs_q   <= 1'b1;
    end else begin
      ctrl_q <= ctrl_nxt;
      vs_q   <= vs;
    end
  end

  assign ctrl = ctrl_q;

endmodule

// File: rtl/vga_text_vram_arbiter.sv
// Shares a single-port VRAM between the Avalon-MM slave and the display fetch path.
// Display fetches always win the port; Avalon requests are stretched with waitrequest.
module vga_text_vram_arbiter
  import vga_text_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  output logic                AVL_WAITREQUEST,
  input  logic                DISP_REQ,
  input  logic [ADDR_W-1:0]   DISP_ADDR,
  output logic [DATA_W-1:0]   DISP_DATA,
  output logic                DISP_VALID,
  output logic [ADDR_W-1:0]   RAM_ADDR,
  output logic                RAM_WE,
  output logic [DATA_W/8-1:0] RAM_BE,
  output logic [DATA_W-1:0]   RAM_WDATA,
  input  logic [DATA_W-1:0]   RAM_RDATA,
  input  logic                VS,
  output logic [DATA_W-1:0]   CTRL
);

  avl_state_e        state;
  logic              pending, avl_vram, avl_ctrl, disp_ram;
  logic              avl_grant, wr_grant, rd_grant, ram_wr;
  logic              rd_ram_q, disp_ram_q;
  logic [DATA_W-1:0] avl_rdata_q, disp_hold_q;

  assign pending  = AVL_CS & (AVL_READ | AVL_WRITE);
  assign avl_vram = AVL_ADDR < ADDR_W'(VRAM_WORDS);
  assign avl_ctrl = AVL_ADDR == ADDR_W'(CTRL_ADDR);
  assign disp_ram = DISP_REQ & (DISP_ADDR < ADDR_W'(VRAM_WORDS));

  // CTRL and unmapped accesses never touch the RAM, so only VRAM accesses yield to display.
  assign avl_grant = pending & (state == IDLE) & ~(avl_vram & disp_ram);
  assign wr_grant  = avl_grant & AVL_WRITE;
  assign rd_grant  = avl_grant & ~AVL_WRITE;
  assign ram_wr    = wr_grant & avl_vram;

  assign AVL_WAITREQUEST = pending & ~(wr_grant | (state == RD_DATA));

  assign RAM_ADDR  = disp_ram ? DISP_ADDR : AVL_ADDR;
  assign RAM_WE    = ram_wr & ~RESET;
  assign RAM_BE    = AVL_BYTE_EN;
  assign RAM_WDATA = AVL_WRITEDATA;

  vga_text_ctrl_reg u_ctrl_reg (
    .clk   (CLK),
    .rst   (RESET),
    .we    (wr_grant & avl_ctrl),
    .be    (AVL_BYTE_EN),
    .wdata (AVL_WRITEDATA),
    .vs    (VS),
    .ctrl  (CTRL)
  );

  // The RAM output register supplies data in the return cycle; the hold registers keep it afterwards.
  assign AVL_READDATA = ((state == RD_DATA) && rd_ram_q) ? RAM_RDATA : avl_rdata_q;
  assign DISP_DATA    = DISP_VALID ? (disp_ram_q ? RAM_RDATA : '0) : disp_hold_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      rd_ram_q    <= 1'b0;
      avl_rdata_q <= '0;
      DISP_VALID  <= 1'b0;
      disp_ram_q  <= 1'b0;
      disp_hold_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_grant) begin
            state    <= RD_DATA;
            rd_ram_q <= avl_vram;
            if (!avl_vram) avl_rdata_q <= avl_ctrl ? CTRL : '0;
          end
        end
        RD_DATA: begin
          state <= IDLE;
          if (rd_ram_q) avl_rdata_q <= RAM_RDATA;
        end
        default: state <= IDLE;
      endcase
      DISP_VALID <= DISP_REQ;
      disp_ram_q <= disp_ram;
      if (DISP_VALID) disp_hold_q <= DISP_DATA;
    end
  end

endmodule
